alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 8..64, even).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 The block SHALL have port start  input  1  request strobe; operands and cmd sampled when start=1 in IDLE.
REQ-005 The block SHALL have port cmd  input  4  operation select (REQ-013).
REQ-006 The block SHALL have port OP1  input  WIDTH  first operand.
REQ-007 The block SHALL have port OP2  input  WIDTH  second operand / shift amount.
REQ-008 The block SHALL have port RES  output  WIDTH  registered result (low half for mul, quotient for div).
REQ-009 The block SHALL have port RES_HI  output  WIDTH  registered high half for mul, remainder for div, 0 otherwise.
REQ-010 The block SHALL have port eq_bit  output  1  registered (OP1==OP2) of the accepted operands, every cmd.
REQ-011 The block SHALL have port ovF  output  1  registered signed overflow (add/sub) or divide-by-zero (div); 0 otherwise.
REQ-012 The block SHALL have ports busy  output  1  (operation in progress) and done  output  1  (one-cycle result-valid pulse).

Function
REQ-013 cmd encoding SHALL be: 0000 add, 0001 sub, 0010 sll, 0011 signed greater-than, 0100 srl, 0101 and, 0110 or, 0111 equal, 1000 unsigned multiply, 1001 unsigned divide, 1010 sra, 1011 xor; 1100-1111 reserved.
REQ-014 FSM states SHALL be IDLE, MUL, DIV; reset state IDLE.
REQ-015 In IDLE with start=1 and a single-cycle cmd (0000-0111, 1010-1011, reserved), the block SHALL register results and assert done on the next edge, staying in IDLE (latency 1, busy never asserted).
REQ-016 In IDLE with start=1 and cmd 1000/1001, the block SHALL latch operands, enter MUL/DIV, and assert busy starting the next cycle.
REQ-017 MUL SHALL be iterative shift-add, one bit per cycle, exactly WIDTH cycles in state; the 2*WIDTH product goes to {RES_HI,RES}, ovF=0.
REQ-018 DIV SHALL be iterative restoring division, one bit per cycle, exactly WIDTH cycles; quotient to RES, remainder to RES_HI.
REQ-019 On the final iteration edge the FSM SHALL return to IDLE, deassert busy and pulse done for one cycle (start-to-done latency WIDTH+1 cycles).
REQ-020 start SHALL be ignored while busy=1; operand/cmd changes during MUL/DIV SHALL not affect the result.
REQ-021 start asserted in IDLE on the same cycle done is high SHALL be accepted (back-to-back issue).
REQ-022 add/sub SHALL be WIDTH-bit modular; ovF=1 when operand signs agree (sub: OP1 and ~OP2) and result sign differs.
REQ-023 Compare ops SHALL give RES=1 when true, else 0; greater-than uses two's-complement interpretation.
REQ-024 Shifts SHALL use full OP2 value: amount >= WIDTH gives 0 for sll/srl and all-sign-bit for sra.
REQ-025 Divide by zero SHALL still take WIDTH+1 cycles and give RES=all ones, RES_HI=OP1, ovF=1.
REQ-026 Reserved cmd SHALL give RES=0, RES_HI=0, ovF=0, done after 1 cycle.
REQ-027 RES, RES_HI, eq_bit, ovF SHALL hold their values until the next done.

Reset
REQ-028 With rst_n=0 at a clock edge: state IDLE, RES=0, RES_HI=0, eq_bit=0, ovF=0, busy=0, done=0, iteration counter 0.
REQ-029 Reset asserted mid-MUL/DIV SHALL abort the operation with no done pulse; start on the first cycle after rst_n returns high SHALL be accepted.

Verification (WIDTH=16)
REQ-030 add 0x7FFF+0x0001 -> RES=0x8000, ovF=1, done at cycle+1, busy=0 throughout.
REQ-031 mul 0xFFFF*0xFFFF -> RES=0x0001, RES_HI=0xFFFE, busy high 16 cycles, done at cycle+17; start pulses during busy ignored.
REQ-032 divu 100/7 -> RES=14, RES_HI=2; divu 5/0 -> RES=0xFFFF, RES_HI=5, ovF=1, both at cycle+17.
REQ-033 sra 0x8000 by 20 -> 0xFFFF; sll 0x0001 by 16 -> 0x0000; gt 0xFFFF vs 0x0001 -> RES=0, eq_bit=0.
REQ-034 rst_n=0 at 8th MUL cycle -> next cycle busy=0, outputs 0, no done; new add 3+4 accepted immediately -> RES=7.
REQ-035 Back-to-back: mul issued on done cycle of prior add -> add result visible one cycle, mul result 17 cycles later.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Most commands finish in one cycle. Unsigned multiply
// (shift-add) and unsigned divide (restoring) run one bit per cycle for WIDTH cycles.
// Ports:
//   clk, rst_n        - clock and synchronous active-low reset
//   start, cmd        - request strobe and operation select (sampled in IDLE only)
//   OP1, OP2          - operands (OP2 is also the shift amount)
//   RES, RES_HI       - result low half / quotient, high half / remainder
//   eq_bit, ovF       - OP1==OP2 of the accepted operands, overflow or divide-by-zero
//   busy, done        - multi-cycle operation in progress, one-cycle result-valid pulse
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic [WIDTH-1:0] RES,
  output logic [WIDTH-1:0] RES_HI,
  output logic             eq_bit,
  output logic             ovF,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt  = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;     // multiplicand / divisor
  logic [WIDTH-1:0] b_q, b_d;     // multiplier (low product) / dividend->quotient
  logic [WIDTH-1:0] acc_q, acc_d; // high product / partial remainder
  logic             eq_pend_q, eq_pend_d;
  logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic             eq_q, eq_d, ovf_q, ovf_d, done_q, done_d;

  // Single-cycle datapath
  logic [WIDTH-1:0] add_sum, sub_diff, sc_res;
  logic             sc_ovf, shamt_big;

  always_comb begin
    add_sum   = OP1 + OP2;
    sub_diff  = OP1 - OP2;
    shamt_big = (OP2 >= WidthVal);
    sc_res    = '0;
    sc_ovf    = 1'b0;
    case (cmd)
      4'b0000: begin
        sc_res = add_sum;
        sc_ovf = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (add_sum[WIDTH-1] != OP1[WIDTH-1]);
      end
      4'b0001: begin
        sc_res = sub_diff;
        sc_ovf = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (sub_diff[WIDTH-1] != OP1[WIDTH-1]);
      end
      4'b0010: sc_res = shamt_big ? '0 : (OP1 << OP2);
      4'b0011: sc_res = {{(WIDTH-1){1'b0}}, ($signed(OP1) > $signed(OP2))};
      4'b0100: sc_res = shamt_big ? '0 : (OP1 >> OP2);
      4'b0101: sc_res = OP1 & OP2;
      4'b0110: sc_res = OP1 | OP2;
      4'b0111: sc_res = {{(WIDTH-1){1'b0}}, (OP1 == OP2)};
      4'b1010: sc_res = shamt_big ? {WIDTH{OP1[WIDTH-1]}} : WIDTH'($signed(OP1) >>> OP2);
      4'b1011: sc_res = OP1 ^ OP2;
      default: sc_res = '0;
    endcase
  end

  // One iteration of each multi-cycle algorithm
  logic [WIDTH:0]   mul_sum, div_r, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] mul_acc, mul_b, div_acc, div_b;

  always_comb begin
    mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
    // Shift the carry-extended sum right into the multiplier register
    mul_acc = mul_sum[WIDTH:1];
    mul_b   = {mul_sum[0], b_q[WIDTH-1:1]};
    div_r   = {acc_q, b_q[WIDTH-1]};
    div_sub = div_r - {1'b0, a_q};
    div_ge  = (div_r >= {1'b0, a_q});
    // Divisor 0 always subtracts: quotient all ones, remainder = dividend
    div_acc = div_ge ? div_sub[WIDTH-1:0] : div_r[WIDTH-1:0];
    div_b   = {b_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    eq_pend_d = eq_pend_q;
    res_d     = res_q;
    res_hi_d  = res_hi_q;
    eq_d      = eq_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d     = '0;
          acc_d     = '0;
          eq_pend_d = (OP1 == OP2);
          if (cmd == 4'b1000) begin
            state_d = StMul;
            a_d     = OP1;
            b_d     = OP2;
          end else if (cmd == 4'b1001) begin
            state_d = StDiv;
            a_d     = OP2;
            b_d     = OP1;
          end else begin
            res_d    = sc_res;
            res_hi_d = '0;
            eq_d     = (OP1 == OP2);
            ovf_d    = sc_ovf;
            done_d   = 1'b1;
          end
        end
      end
      StMul, StDiv: begin
        acc_d = (state_q == StMul) ? mul_acc : div_acc;
        b_d   = (state_q == StMul) ? mul_b : div_b;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d  = StIdle;
          res_d    = b_d;
          res_hi_d = acc_d;
          eq_d     = eq_pend_q;
          ovf_d    = (state_q == StDiv) && (a_q == '0);
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      eq_pend_q <= 1'b0;
      res_q     <= '0;
      res_hi_q  <= '0;
      eq_q      <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      eq_pend_q <= eq_pend_d;
      res_q     <= res_d;
      res_hi_q  <= res_hi_d;
      eq_q      <= eq_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign RES    = res_q;
  assign RES_HI = res_hi_q;
  assign eq_bit = eq_q;
  assign ovF    = ovf_q;
  assign busy   = (state_q != StIdle);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16): vector table plus multi-cycle sequences.
module tb_alu_seq;
  localparam int unsigned W    = 16;
  localparam int          NVec = 25;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [3:0]    cmd;
  logic [W-1:0]  op1, op2, res, res_hi;
  logic          eq_bit, ovf, busy, done;
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmd    (cmd),
    .OP1    (op1),
    .OP2    (op2),
    .RES    (res),
    .RES_HI (res_hi),
    .eq_bit (eq_bit),
    .ovF    (ovf),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic [15:0] a, b, res, hi;
    logic        eq, ovf;
  } vec_t;

  vec_t vecs[NVec];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int lat, bcnt, exp_lat;
    string tag;
    tag     = $sformatf("vec%0d", i);
    exp_lat = (vecs[i].cmd == 4'h8 || vecs[i].cmd == 4'h9) ? W + 1 : 1;
    @(negedge clk);
    start = 1'b1; cmd = vecs[i].cmd; op1 = vecs[i].a; op2 = vecs[i].b;
    @(negedge clk);
    // Scramble operands after acceptance; the result must not depend on them
    start = 1'b0; op1 = ~vecs[i].a; op2 = 16'h0003;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      bcnt += busy ? 1 : 0;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
    chk({tag, "_res"}, 64'(res), 64'(vecs[i].res));
    chk({tag, "_res_hi"}, 64'(res_hi), 64'(vecs[i].hi));
    chk({tag, "_eq_bit"}, 64'(eq_bit), 64'(vecs[i].eq));
    chk({tag, "_ovf"}, 64'(ovf), 64'(vecs[i].ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int lat, ndone;
    vecs[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b1};
    vecs[1]  = '{4'h0, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b1};
    vecs[3]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{4'h2, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{4'h2, 16'h0001, 16'h000F, 16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{4'h3, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{4'h3, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{4'h4, 16'h8000, 16'h0004, 16'h0800, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{4'h4, 16'hFFFF, 16'h0064, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{4'h5, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{4'h6, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{4'h7, 16'h1234, 16'h1234, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{4'hA, 16'h8000, 16'h0014, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{4'hA, 16'h8000, 16'h0001, 16'hC000, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{4'hB, 16'hAAAA, 16'hFFFF, 16'h5555, 16'h0000, 1'b0, 1'b0};
    vecs[16] = '{4'hC, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[17] = '{4'hF, 16'h5555, 16'h5555, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[18] = '{4'h8, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0};
    vecs[19] = '{4'h8, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 1'b0};
    vecs[20] = '{4'h9, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0};
    vecs[21] = '{4'h9, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b0, 1'b1};
    vecs[22] = '{4'h9, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[23] = '{4'h0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[24] = '{4'h1, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; cmd = 4'h0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_res", 64'(res), 64'h0);
    chk("reset_res_hi", 64'(res_hi), 64'h0);
    chk("reset_eq_bit", 64'(eq_bit), 64'h0);
    chk("reset_ovf", 64'(ovf), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NVec; i++) run_vec(i);

    // Multiply with start pulses and operand changes while busy
    @(negedge clk);
    start = 1'b1; cmd = 4'h8; op1 = 16'hFFFF; op2 = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      start = (lat >= 2 && lat <= 10); cmd = 4'h0; op1 = 16'(lat); op2 = 16'h1111;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("mulbusy_latency", 64'(lat), 64'(W + 1));
    chk("mulbusy_res", 64'(res), 64'h0001);
    chk("mulbusy_res_hi", 64'(res_hi), 64'hFFFE);
    chk("mulbusy_eq_bit", 64'(eq_bit), 64'h1);
    @(negedge clk);
    chk("mulbusy_done_one_cycle", 64'(done), 64'h0);
    chk("mulbusy_res_hold", 64'(res), 64'h0001);
    chk("mulbusy_hi_hold", 64'(res_hi), 64'hFFFE);

    // Reset on the 8th multiply cycle
    @(negedge clk);
    start = 1'b1; cmd = 4'h8; op1 = 16'h1234; op2 = 16'h0010;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    chk("abort_res", 64'(res), 64'h0);
    chk("abort_res_hi", 64'(res_hi), 64'h0);
    chk("abort_eq_bit", 64'(eq_bit), 64'h0);
    rst_n = 1'b1; start = 1'b1; cmd = 4'h0; op1 = 16'h0003; op2 = 16'h0004;
    @(negedge clk);
    start = 1'b0;
    chk("abort_add_done", 64'(done), 64'h1);
    chk("abort_add_res", 64'(res), 64'h0007);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      ndone += done ? 1 : 0;
    end
    chk("abort_no_late_done", 64'(ndone), 64'h0);

    // Back-to-back: multiply issued on the done cycle of an add
    @(negedge clk);
    start = 1'b1; cmd = 4'h0; op1 = 16'h0010; op2 = 16'h0020;
    @(negedge clk);
    chk("b2b_add_done", 64'(done), 64'h1);
    chk("b2b_add_res", 64'(res), 64'h0030);
    chk("b2b_add_busy", 64'(busy), 64'h0);
    start = 1'b1; cmd = 4'h8; op1 = 16'h1234; op2 = 16'h0010;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_add_done_one_cycle", 64'(done), 64'h0);
    chk("b2b_add_res_hold", 64'(res), 64'h0030);
    chk("b2b_mul_busy", 64'(busy), 64'h1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_mul_latency", 64'(lat), 64'(W + 1));
    chk("b2b_mul_res", 64'(res), 64'h2340);
    chk("b2b_mul_res_hi", 64'(res_hi), 64'h0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
